// File: rtl/cordic_pkg.sv
// Shared float-field constants and the packed IEEE-754 single-precision layout
// used by the CORDIC back end.
package cordic_pkg;
  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;
  localparam int F32_EXP_W  = 8;
  localparam int LOD_W      = 5;

  typedef struct packed {
    logic                  sign;
    logic [F32_EXP_W-1:0]  exp;
    logic [F32_MANT_W-1:0] mant;
  } f32_t;
endpackage

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector: position of the highest set bit of din,
// plus a flag for an all-zero input.
module leading_one_detect
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic [WIDTH-1:0] din,
  output logic [LOD_W-1:0] pos,
  output logic             zero
);
  always_comb begin
    pos  = '0;
    zero = (din == '0);
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < WIDTH; i++)
      if (din[i]) pos = LOD_W'(i);
  end
endmodule

// File: rtl/cordic_fix2float.sv
// Three-stage signed fixed-point to IEEE-754 single converter behind the CORDIC pipe.
// Optional debug ports behind macro CORDIC_F2F_DEBUG_EN.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int FRAC  = 20
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] fixed_in,
  output logic [31:0]      result,
  output logic             valid_out
`ifdef CORDIC_F2F_DEBUG_EN
  ,
  output logic [4:0]       lead_pos_debug,
  output logic [7:0]       exponent_debug
`endif
);
  localparam int NORM_W = WIDTH + F32_MANT_W;

  logic              sign1_q, sign1_d, sign2_q, sign2_d;
  logic [WIDTH-1:0]  mag1_q, mag1_d, mag2_q, mag2_d;
  logic [LOD_W-1:0]  p2_q, p2_d;
  logic signed [8:0] exp2_q, exp2_d;
  logic              zero2_q, zero2_d;
  logic [2:0]        vld_pipe_q, vld_pipe_d;
  logic [31:0]       result_q, result_d;

  logic [LOD_W-1:0]      lod_pos;
  logic                  lod_zero;
  logic [F32_MANT_W-1:0] mant;
  f32_t                  pk;

  leading_one_detect #(.WIDTH(WIDTH)) u_lod (
    .din  (mag1_q),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  always_comb begin
    sign1_d    = fixed_in[WIDTH-1];
    // Unsigned WIDTH-bit view makes -2^(WIDTH-1) come out as 2^(WIDTH-1).
    mag1_d     = fixed_in[WIDTH-1] ? -fixed_in : fixed_in;
    sign2_d    = sign1_q;
    mag2_d     = mag1_q;
    p2_d       = lod_pos;
    zero2_d    = lod_zero;
    exp2_d     = 9'(F32_BIAS) + 9'(lod_pos) - 9'(FRAC);
    vld_pipe_d = {vld_pipe_q[1:0], valid_in};

    // One shifter covers both directions: pre-shift left by 23, then right by p.
    mant = F32_MANT_W'(({{F32_MANT_W{1'b0}}, mag2_q} << F32_MANT_W) >> p2_q);

    pk.sign = sign2_q;
    pk.exp  = exp2_q[7:0];
    pk.mant = mant;
    if (zero2_q) begin
      pk = '0;
    end else if (exp2_q < 9'sd1 || exp2_q > 9'sd254) begin
      pk.exp  = '0;
      pk.mant = '0;
    end
    result_d = vld_pipe_q[1] ? pk : result_q;
  end

  always_ff @(posedge clock) begin
    if (!aclr) begin
      sign1_q    <= 1'b0;
      mag1_q     <= '0;
      sign2_q    <= 1'b0;
      mag2_q     <= '0;
      p2_q       <= '0;
      exp2_q     <= '0;
      zero2_q    <= 1'b0;
      vld_pipe_q <= '0;
      result_q   <= '0;
    end else if (clk_en) begin
      sign1_q    <= sign1_d;
      mag1_q     <= mag1_d;
      sign2_q    <= sign2_d;
      mag2_q     <= mag2_d;
      p2_q       <= p2_d;
      exp2_q     <= exp2_d;
      zero2_q    <= zero2_d;
      vld_pipe_q <= vld_pipe_d;
      result_q   <= result_d;
    end
  end

  assign result    = result_q;
  assign valid_out = vld_pipe_q[2];

`ifdef CORDIC_F2F_DEBUG_EN
  assign lead_pos_debug = aclr ? p2_q : '0;
  assign exponent_debug = aclr ? exp2_q[7:0] : '0;
`endif
endmodule

// File: tb/tb_cordic_fix2float.sv
// Self-checking bench for cordic_fix2float: directed phases plus random traffic
// compared against a plain-arithmetic float conversion model.
module tb_cordic_fix2float;
  logic        clock = 1'b0;
  logic        aclr, clk_en, valid_in, valid_in_w;
  logic [21:0] fixed_in;
  logic [31:0] fixed_in_w;
  logic [31:0] result, result_w;
  logic        valid_out, valid_out_w;
`ifdef CORDIC_F2F_DEBUG_EN
  logic [4:0]  lp_dbg, lp_dbg_w;
  logic [7:0]  ex_dbg, ex_dbg_w;
`endif

  int n_chk = 0, n_fail = 0;
  logic [32:0] hist[$];
  logic [31:0] out_log[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_result = '0;

  always #5 clock = ~clock;

  cordic_fix2float #(.WIDTH(22), .FRAC(20)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .valid_in(valid_in),
    .fixed_in(fixed_in), .result(result), .valid_out(valid_out)
`ifdef CORDIC_F2F_DEBUG_EN
    , .lead_pos_debug(lp_dbg), .exponent_debug(ex_dbg)
`endif
  );

  cordic_fix2float #(.WIDTH(32), .FRAC(30)) dut_w (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .valid_in(valid_in_w),
    .fixed_in(fixed_in_w), .result(result_w), .valid_out(valid_out_w)
`ifdef CORDIC_F2F_DEBUG_EN
    , .lead_pos_debug(lp_dbg_w), .exponent_debug(ex_dbg_w)
`endif
  );

  // Real-valued meaning: value = v * 2^-frac; float is sign, floor(log2) exponent,
  // truncated mantissa; zero -> +0, out-of-range exponent -> signed zero.
  function automatic logic [31:0] f2f(input longint v, input int frac);
    longint m;
    int e, ex;
    logic [31:0] mant;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    ex = 127 + e - frac;
    if (ex < 1 || ex > 254) return {v < 0, 31'b0};
    mant = 32'((e <= 23) ? (m << (23 - e)) : (m >> (e - 23))) & 32'h007F_FFFF;
    return {v < 0, 8'(ex), mant[22:0]};
  endfunction

  function automatic longint sx22(input logic [21:0] d);
    return d[21] ? longint'(d) - 64'sd4194304 : longint'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic rst_n, input logic v, input logic [21:0] d);
    clk_en = en; aclr = rst_n; valid_in = v; fixed_in = d;
    @(posedge clock);
    #1;
    if (!rst_n) begin
      hist.delete();
      m_valid  = 1'b0;
      m_result = '0;
    end else if (en) begin
      hist.push_back({v, f2f(sx22(d), 20)});
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3) begin
        m_valid = hist[0][32];
        if (m_valid) m_result = hist[0][31:0];
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    chk("result", result, m_result);
    if (valid_out && en && rst_n) out_log.push_back(result);
  endtask

  logic [31:0] nom_exp[6] = '{32'h3F800000, 32'h3F000000, 32'hBF800000,
                              32'h00000000, 32'hC0000000, 32'h35800000};
  logic [21:0] nom_in[6]  = '{22'h100000, 22'h080000, 22'h300000,
                              22'h000000, 22'h200000, 22'h000001};
  logic [31:0] w_in[6];

  initial begin
    aclr = 1'b0; clk_en = 1'b1; valid_in = 1'b0; fixed_in = '0;
    valid_in_w = 1'b0; fixed_in_w = '0;

    // Reset held with valid traffic present, then two quiet cycles after release.
    step(1, 0, 1, 22'h100000);
    step(1, 0, 1, 22'h100000);
    chk("reset_result_w", result_w, 32'h0);
    chk("reset_valid_w", {31'b0, valid_out_w}, 32'h0);
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);

    // Nominal back-to-back values.
    out_log.delete();
    for (int i = 0; i < 6; i++) step(1, 1, 1, nom_in[i]);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    chk("nominal_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++) chk("nominal_value", out_log[i], nom_exp[i]);

    // Stall mid-stream: inputs during clk_en=0 must be ignored.
    out_log.delete();
    step(1, 1, 1, 22'h040000);
    step(1, 1, 1, 22'h0C0000);
    step(0, 1, 1, 22'h3FFFFF);
    step(0, 1, 1, 22'h3FFFFF);
    step(1, 1, 1, 22'h380000);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    chk("stall_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk("stall_0", out_log[0], 32'h3E800000);
      chk("stall_1", out_log[1], 32'h3F400000);
      chk("stall_2", out_log[2], 32'hBF000000);
    end

    // Valid bubbles.
    step(1, 1, 1, 22'h0A0000);
    step(1, 1, 0, 22'h155555);
    step(1, 1, 1, 22'h2AAAAA);
    step(1, 1, 1, 22'h000010);
    step(1, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

    // Reset with three samples in flight, then a fresh sample at latency 3.
    step(1, 1, 1, 22'h100000);
    step(1, 1, 1, 22'h080000);
    step(1, 1, 1, 22'h200000);
    step(1, 0, 0, '0);
    step(1, 1, 1, 22'h100000);
    step(1, 1, 0, '0);
    chk("midrst_quiet", {31'b0, valid_out}, 32'h0);
    step(1, 1, 0, '0);
    chk("midrst_valid", {31'b0, valid_out}, 32'h1);
    chk("midrst_result", result, 32'h3F800000);

    // Wide instance: truncation case followed by random values.
    w_in[0] = 32'h3FFFFFFF;
    for (int i = 1; i < 6; i++) w_in[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      valid_in_w = (i < 6);
      fixed_in_w = (i < 6) ? w_in[i] : '0;
      step(1, 1, 0, '0);
      if (i >= 2) begin
        chk("wide_valid", {31'b0, valid_out_w}, 32'h1);
        chk("wide_result", result_w, f2f(longint'($signed(w_in[i-2])), 30));
      end
    end
    chk("wide_trunc_model", f2f(longint'(32'h3FFFFFFF), 30), 32'h3F7FFFFF);
    valid_in_w = 1'b0;

    // Random traffic with stalls, bubbles and corner values.
    for (int i = 0; i < 300; i++) begin
      logic [21:0] d;
      case ($urandom_range(0, 7))
        0: d = 22'h200000;
        1: d = 22'h000000;
        2: d = 22'h000001;
        3: d = 22'h1FFFFF;
        default: d = 22'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
